// File: rtl/mcdf_fmt_pkg.sv
// mcdf_fmt_pkg
// Shared types and constants for the MCDF formatter scheduler: FSM state
// encoding, channel count, length/channel-id widths and the length clamp.
package mcdf_fmt_pkg;

  localparam int NUM_CH  = 3;
  localparam int LEN_W   = 6;
  localparam int MAX_LEN = 32;
  localparam int CHID_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Map a programmed packet length onto the legal range 1..MAX_LEN.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] res;
    if (len == 6'd0) begin
      res = 6'd1;
    end else if (len > LEN_W'(MAX_LEN)) begin
      res = LEN_W'(MAX_LEN);
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/mcdf_rr_arb.sv
// mcdf_rr_arb
// Three-way round-robin arbiter. The search starts at the channel after the
// last-served pointer and wraps around, so the pointer channel itself has the
// lowest priority.
// Ports:
//   req   [2:0] in   request vector, bit N = channel N
//   ptr   [1:0] in   last-served channel
//   gnt   [2:0] out  one-hot grant (zero when no request)
//   valid       out  at least one request present
module mcdf_rr_arb
  import mcdf_fmt_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CHID_W-1:0] ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic              valid
);

  // Rotating priority select; pointer value 3 is unreachable and behaves as 2.
  always_comb begin
    gnt = 3'b000;
    case (ptr)
      2'd0: begin
        if      (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else             gnt = 3'b000;
      end
      2'd1: begin
        if      (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else             gnt = 3'b000;
      end
      default: begin
        if      (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else             gnt = 3'b000;
      end
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/mcdf_fmt_sched.sv
// mcdf_fmt_sched
// Packet scheduler between three channel FWFT FIFOs and the formatter.
// In IDLE it picks an eligible channel round-robin, requests the formatter in
// REQ, and streams fmt_length words back-to-back in SEND.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_ch_en, cfg_pkt_len   channel enables and packet length (sampled in IDLE)
//   chN_avail/chN_data/chN_pop  per-channel FIFO fill level, head word, pop
//   fmt_req/fmt_chid/fmt_length/fmt_grant  formatter handshake
//   fmt_data/fmt_start/fmt_end packet word stream
//   err_timeout              one-cycle pulse when a grant wait times out
// Optional feature: define FMT_SCHED_TIMEOUT_EN to abandon a request after
// TMO_CYC cycles without grant; otherwise REQ waits forever.
module mcdf_fmt_sched
  import mcdf_fmt_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cfg_ch_en,
  input  logic [5:0]        cfg_pkt_len,
  input  logic [5:0]        ch0_avail,
  input  logic [5:0]        ch1_avail,
  input  logic [5:0]        ch2_avail,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic [DATA_W-1:0] ch2_data,
  output logic              ch0_pop,
  output logic              ch1_pop,
  output logic              ch2_pop,
  output logic              fmt_req,
  output logic [1:0]        fmt_chid,
  output logic [5:0]        fmt_length,
  input  logic              fmt_grant,
  output logic [DATA_W-1:0] fmt_data,
  output logic              fmt_start,
  output logic              fmt_end,
  output logic              err_timeout
);

  state_e            state_q, state_d;
  logic [CHID_W-1:0] ptr_q, ptr_d;
  logic [CHID_W-1:0] chid_q, chid_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  eff_len_s;
  logic [NUM_CH-1:0] elig_s, arb_gnt_s, pop_s;
  logic [CHID_W-1:0] arb_chid_s;
  logic              arb_valid_s;
  logic              last_s;
  logic              tmo_hit_s;

  assign eff_len_s = clamp_len(cfg_pkt_len);
  assign elig_s = {cfg_ch_en[2] && (ch2_avail >= eff_len_s),
                   cfg_ch_en[1] && (ch1_avail >= eff_len_s),
                   cfg_ch_en[0] && (ch0_avail >= eff_len_s)};

  mcdf_rr_arb u_arb (
    .req   (elig_s),
    .ptr   (ptr_q),
    .gnt   (arb_gnt_s),
    .valid (arb_valid_s)
  );

  // Convert the one-hot arbiter grant into a channel id.
  always_comb begin
    case (arb_gnt_s)
      3'b010:  arb_chid_s = 2'd1;
      3'b100:  arb_chid_s = 2'd2;
      default: arb_chid_s = 2'd0;
    endcase
  end

  assign last_s = (cnt_q == (len_q - 6'd1));

`ifdef FMT_SCHED_TIMEOUT_EN
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;

  // tmo_cnt_q counts completed REQ cycles, so the request is visible TMO_CYC cycles.
  assign tmo_hit_s = (tmo_cnt_q == TMO_W'(TMO_CYC - 1));

  // Grant-wait counter and timeout pulse next values.
  always_comb begin
    if ((state_q == ST_REQ) && !fmt_grant && !tmo_hit_s) begin
      tmo_cnt_d = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_d = '0;
    end
    err_d = (state_q == ST_REQ) && !fmt_grant && tmo_hit_s;
  end

  // Grant-wait counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_tmo_s;
  assign unused_tmo_s = ^TMO_CYC;
  assign tmo_hit_s    = 1'b0;
  assign err_timeout  = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) state_d = ST_REQ;
        else             state_d = ST_IDLE;
      end
      ST_REQ: begin
        if      (fmt_grant) state_d = ST_SEND;
        else if (tmo_hit_s) state_d = ST_IDLE;
        else                state_d = ST_REQ;
      end
      ST_SEND: begin
        if (last_s) state_d = ST_IDLE;
        else        state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Packet context next values: latched only at arbitration, pointer only on grant.
  always_comb begin
    ptr_d  = ptr_q;
    chid_d = chid_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          chid_d = arb_chid_s;
          len_d  = eff_len_s;
        end else begin
          chid_d = chid_q;
        end
      end
      ST_REQ: begin
        if (fmt_grant) begin
          ptr_d = chid_q;
          cnt_d = 6'd0;
        end else begin
          ptr_d = ptr_q;
        end
      end
      ST_SEND: begin
        if (!last_s) cnt_d = cnt_q + 6'd1;
        else         cnt_d = cnt_q;
      end
      default: cnt_d = 6'd0;
    endcase
  end

  // Packet context registers; pointer resets to 2 so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= 2'd2;
      chid_q <= 2'd0;
      len_q  <= 6'd0;
      cnt_q  <= 6'd0;
    end else begin
      ptr_q  <= ptr_d;
      chid_q <= chid_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
    end
  end

  // FSM outputs; the word path is combinational from the latched channel's head.
  always_comb begin
    pop_s     = 3'b000;
    fmt_data  = '0;
    fmt_start = 1'b0;
    fmt_end   = 1'b0;
    fmt_req   = (state_q == ST_REQ);
    if (state_q == ST_SEND) begin
      fmt_start = (cnt_q == 6'd0);
      fmt_end   = last_s;
      case (chid_q)
        2'd1: begin
          pop_s    = 3'b010;
          fmt_data = ch1_data;
        end
        2'd2: begin
          pop_s    = 3'b100;
          fmt_data = ch2_data;
        end
        default: begin
          pop_s    = 3'b001;
          fmt_data = ch0_data;
        end
      endcase
    end else begin
      pop_s = 3'b000;
    end
  end

  assign ch0_pop    = pop_s[0];
  assign ch1_pop    = pop_s[1];
  assign ch2_pop    = pop_s[2];
  assign fmt_chid   = chid_q;
  assign fmt_length = len_q;

endmodule

// File: tb/tb_mcdf_fmt_sched.sv
// tb_mcdf_fmt_sched
// Directed bench for mcdf_fmt_sched: reset state, single packet, round-robin
// order and inter-packet gap, length-1 and clamped lengths, eligibility
// threshold, grant wait (with or without FMT_SCHED_TIMEOUT_EN) and mid-packet reset.
module tb_mcdf_fmt_sched;

  localparam int DATA_W = 32;
  localparam logic [31:0] W0 = 32'hC0DE_0A00;
  localparam logic [31:0] W1 = 32'hC0DE_1B11;
  localparam logic [31:0] W2 = 32'hC0DE_2C22;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        cfg_ch_en;
  logic [5:0]        cfg_pkt_len;
  logic [5:0]        ch0_avail, ch1_avail, ch2_avail;
  logic [DATA_W-1:0] ch0_data, ch1_data, ch2_data;
  logic              ch0_pop, ch1_pop, ch2_pop;
  logic              fmt_req;
  logic [1:0]        fmt_chid;
  logic [5:0]        fmt_length;
  logic              fmt_grant;
  logic [DATA_W-1:0] fmt_data;
  logic              fmt_start, fmt_end, err_timeout;
  logic [2:0]        pops_s;

  int n_checks = 0;
  int n_fail   = 0;

  assign pops_s = {ch2_pop, ch1_pop, ch0_pop};

  always #5 clk = ~clk;

  mcdf_fmt_sched #(.DATA_W(DATA_W), .TMO_CYC(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_ch_en   (cfg_ch_en),
    .cfg_pkt_len (cfg_pkt_len),
    .ch0_avail   (ch0_avail),
    .ch1_avail   (ch1_avail),
    .ch2_avail   (ch2_avail),
    .ch0_data    (ch0_data),
    .ch1_data    (ch1_data),
    .ch2_data    (ch2_data),
    .ch0_pop     (ch0_pop),
    .ch1_pop     (ch1_pop),
    .ch2_pop     (ch2_pop),
    .fmt_req     (fmt_req),
    .fmt_chid    (fmt_chid),
    .fmt_length  (fmt_length),
    .fmt_grant   (fmt_grant),
    .fmt_data    (fmt_data),
    .fmt_start   (fmt_start),
    .fmt_end     (fmt_end),
    .err_timeout (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] chan_word(input int ch);
    if (ch == 1)      return W1;
    else if (ch == 2) return W2;
    else              return W0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " req"},    32'(fmt_req),     32'd0);
    chk({tag, " chid"},   32'(fmt_chid),    32'd0);
    chk({tag, " len"},    32'(fmt_length),  32'd0);
    chk({tag, " pops"},   32'(pops_s),      32'd0);
    chk({tag, " start"},  32'(fmt_start),   32'd0);
    chk({tag, " end"},    32'(fmt_end),     32'd0);
    chk({tag, " data"},   fmt_data,         32'd0);
    chk({tag, " err"},    32'(err_timeout), 32'd0);
  endtask

  // Call on the first SEND cycle; returns positioned on the last word.
  task automatic send_check(input string tag, input int ch, input int len);
    logic [2:0] oh;
    oh = 3'b001 << ch;
    chk({tag, " req_low"}, 32'(fmt_req), 32'd0);
    for (int i = 0; i < len; i++) begin
      chk({tag, " pop"},   32'(pops_s),    32'(oh));
      chk({tag, " start"}, 32'(fmt_start), (i == 0) ? 32'd1 : 32'd0);
      chk({tag, " end"},   32'(fmt_end),   (i == len - 1) ? 32'd1 : 32'd0);
      chk({tag, " data"},  fmt_data,       chan_word(ch));
      if (i < len - 1) tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    int exp_order [4];
    exp_order = '{0, 1, 2, 0};

    rst = 1'b1;
    cfg_ch_en = 3'b000; cfg_pkt_len = 6'd0;
    ch0_avail = 6'd0; ch1_avail = 6'd0; ch2_avail = 6'd0;
    ch0_data = W0; ch1_data = W1; ch2_data = W2;
    fmt_grant = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Single 4-word packet from channel 0, grant one cycle after request.
    cfg_ch_en = 3'b111; cfg_pkt_len = 6'd4; ch0_avail = 6'd8;
    tick();
    chk("p1 req",  32'(fmt_req),    32'd1);
    chk("p1 chid", 32'(fmt_chid),   32'd0);
    chk("p1 len",  32'(fmt_length), 32'd4);
    fmt_grant = 1'b1;
    tick();
    fmt_grant = 1'b0;
    send_check("p1", 0, 4);
    cfg_ch_en = 3'b000;
    tick();
    chk("p1 idle req",  32'(fmt_req),    32'd0);
    chk("p1 idle pops", 32'(pops_s),     32'd0);
    chk("p1 idle data", fmt_data,        32'd0);
    chk("p1 hold len",  32'(fmt_length), 32'd4);
    tick();
    chk("p1 quiet req", 32'(fmt_req), 32'd0);

    // Round-robin order 0,1,2,0 with continuous grant and a two-cycle gap.
    do_reset();
    cfg_ch_en = 3'b111; cfg_pkt_len = 6'd8;
    ch0_avail = 6'd32; ch1_avail = 6'd32; ch2_avail = 6'd32;
    fmt_grant = 1'b1;
    tick();
    for (int p = 0; p < 4; p++) begin
      chk("rr req",  32'(fmt_req),    32'd1);
      chk("rr chid", 32'(fmt_chid),   32'(exp_order[p]));
      chk("rr len",  32'(fmt_length), 32'd8);
      tick();
      send_check("rr", exp_order[p], 8);
      tick();
      chk("rr gap req",  32'(fmt_req), 32'd0);
      chk("rr gap pops", 32'(pops_s),  32'd0);
      if (p == 3) cfg_ch_en = 3'b000;
      tick();
    end
    chk("rr quiet req", 32'(fmt_req), 32'd0);

    // Length 1 with only channel 1 enabled.
    cfg_ch_en = 3'b010; cfg_pkt_len = 6'd1;
    tick();
    chk("l1 chid", 32'(fmt_chid),   32'd1);
    chk("l1 len",  32'(fmt_length), 32'd1);
    tick();
    send_check("l1", 1, 1);
    cfg_ch_en = 3'b000;
    tick();
    chk("l1 after pops", 32'(pops_s), 32'd0);
    chk("l1 after end",  32'(fmt_end), 32'd0);
    tick();
    chk("grant ignored idle", 32'(fmt_req), 32'd0);

    // Length 0 behaves as 1; length 45 clamps to 32 and holds through REQ.
    cfg_ch_en = 3'b001; cfg_pkt_len = 6'd0;
    tick();
    chk("len0 len",  32'(fmt_length), 32'd1);
    chk("len0 chid", 32'(fmt_chid),   32'd0);
    tick();
    send_check("len0", 0, 1);
    cfg_pkt_len = 6'd45; fmt_grant = 1'b0;
    tick();
    tick();
    chk("len45 req", 32'(fmt_req),    32'd1);
    chk("len45 len", 32'(fmt_length), 32'd32);
    cfg_pkt_len = 6'd2;
    tick();
    chk("cfg stable req", 32'(fmt_req),    32'd1);
    chk("cfg stable len", 32'(fmt_length), 32'd32);

    // Eligibility threshold on channel 2, then an ungranted request.
    do_reset();
    cfg_ch_en = 3'b111; cfg_pkt_len = 6'd4;
    ch0_avail = 6'd0; ch1_avail = 6'd0; ch2_avail = 6'd3;
    tick();
    chk("avail3 req a", 32'(fmt_req), 32'd0);
    tick();
    chk("avail3 req b", 32'(fmt_req), 32'd0);
    ch2_avail = 6'd4;
    tick();
    chk("avail4 req",  32'(fmt_req),  32'd1);
    chk("avail4 chid", 32'(fmt_chid), 32'd2);
    hi_cnt = 1;
`ifdef FMT_SCHED_TIMEOUT_EN
    for (int i = 0; i < 300; i++) begin
      tick();
      if (fmt_req === 1'b1 && pops_s === 3'b000) hi_cnt++;
      else break;
    end
    chk("tmo req cycles", 32'(hi_cnt),      32'd255);
    chk("tmo err pulse",  32'(err_timeout), 32'd1);
    chk("tmo pops",       32'(pops_s),      32'd0);
    cfg_ch_en = 3'b000;
    tick();
    chk("tmo err low", 32'(err_timeout), 32'd0);
    chk("tmo req low", 32'(fmt_req),     32'd0);
`else
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (fmt_req === 1'b1 && pops_s === 3'b000 && err_timeout === 1'b0) hi_cnt++;
    end
    chk("wait req held", 32'(hi_cnt),      32'd1001);
    chk("wait no err",   32'(err_timeout), 32'd0);
`endif

    // Reset on the third word of an 8-word channel-1 packet.
    do_reset();
    cfg_ch_en = 3'b010; cfg_pkt_len = 6'd8;
    ch0_avail = 6'd32; ch1_avail = 6'd32; ch2_avail = 6'd32;
    fmt_grant = 1'b1;
    tick();
    chk("mr chid", 32'(fmt_chid), 32'd1);
    tick();
    chk("mr w0 pop", 32'(pops_s), 32'b010);
    tick();
    tick();
    chk("mr w2 pop",   32'(pops_s),    32'b010);
    chk("mr w2 start", 32'(fmt_start), 32'd0);
    rst = 1'b1;
    tick();
    chk_all_zero("mid reset");
    rst = 1'b0;
    cfg_ch_en = 3'b111;
    tick();
    chk("mr rearb req",  32'(fmt_req),  32'd1);
    chk("mr rearb chid", 32'(fmt_chid), 32'd0);
    chk("mr rearb pops", 32'(pops_s),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
